// File: rtl/mipi_tx_packetizer.sv
// CSI-2 style TX packetizer: header + payload + CRC-16 footer on 32-bit lane-ordered words; header 1 cycle after cmd, payload word 1 cycle after beat, no downstream backpressure.
// Define MIPI_TX_CRC_EN to compute the payload CRC; otherwise the footer bytes are zero with identical placement and timing.
module mipi_tx_packetizer #(
   parameter int DATA_WIDTH = 32,
   parameter int GAP_CYCLES = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  cmd_valid,
   output logic                  cmd_ready,
   input  logic [1:0]            cmd_vc,
   input  logic [5:0]            cmd_dt,
   input  logic [15:0]           cmd_wc,
   input  logic [DATA_WIDTH-1:0] s_data,
   input  logic                  s_valid,
   output logic                  s_ready,
   input  logic                  s_last,
   output logic [DATA_WIDTH-1:0] mipi_data,
   output logic                  mipi_valid,
   output logic                  end_of_packet,
   output logic                  len_err,
   output logic                  underrun
);

   // The header word is emitted on the IDLE exit edge, so the first payload beat can follow it directly.
   typedef enum logic [1:0] {IDLE, PAYLOAD, FOOTER, GAP} state_t;

   localparam logic [15:0] GAP_LAST = 16'(GAP_CYCLES);

   state_t      state;
   logic [1:0]  r_q;
   logic [14:0] beats_left;
   logic        early_last;
   logic [15:0] gap_cnt;

   logic [23:0] hdr;
   logic [31:0] header_word;
   logic [14:0] beats_total;
   logic        is_short;
   logic        last_beat;
   logic [15:0] crc_next;
   logic [15:0] crc_hold;
   logic [31:0] last_word;

   function automatic logic [5:0] hdr_ecc(input logic [23:0] d);
      logic [5:0] p;
      p[0] = d[0]^d[1]^d[2]^d[4]^d[5]^d[7]^d[10]^d[11]^d[13]^d[16]^d[20]^d[21]^d[22]^d[23];
      p[1] = d[0]^d[1]^d[3]^d[4]^d[6]^d[8]^d[10]^d[12]^d[14]^d[17]^d[20]^d[21]^d[22]^d[23];
      p[2] = d[0]^d[2]^d[3]^d[5]^d[6]^d[9]^d[11]^d[12]^d[15]^d[18]^d[20]^d[21]^d[22];
      p[3] = d[1]^d[2]^d[3]^d[7]^d[8]^d[9]^d[13]^d[14]^d[15]^d[19]^d[20]^d[21]^d[23];
      p[4] = d[4]^d[5]^d[6]^d[7]^d[8]^d[9]^d[16]^d[17]^d[18]^d[19]^d[20]^d[22]^d[23];
      p[5] = d[10]^d[11]^d[12]^d[13]^d[14]^d[15]^d[16]^d[17]^d[18]^d[19]^d[21]^d[22]^d[23];
      return p;
   endfunction

   assign hdr         = {cmd_wc, cmd_vc, cmd_dt};
   assign header_word = {2'b00, hdr_ecc(hdr), hdr};
   assign beats_total = {1'b0, cmd_wc[15:2]} + 15'(|cmd_wc[1:0]);
   assign is_short    = (cmd_dt[5:4] == 2'b00);
   assign last_beat   = (beats_left == 15'd1);

`ifdef MIPI_TX_CRC_EN
   logic [15:0] crc_q;
   logic [3:0]  beat_mask;
   logic        beat_fire;

   function automatic logic [15:0] crc_byte(input logic [15:0] c, input logic [7:0] b);
      logic [15:0] x;
      x = c ^ {8'h00, b};
      for (int i = 0; i < 8; i++)
         x = x[0] ? ((x >> 1) ^ 16'h8408) : (x >> 1);
      return x;
   endfunction

   function automatic logic [15:0] crc_beat(input logic [15:0] c, input logic [31:0] d,
                                            input logic [3:0] m);
      logic [15:0] x;
      x = c;
      for (int k = 0; k < 4; k++)
         if (m[k]) x = crc_byte(x, d[8*k +: 8]);
      return x;
   endfunction

   // Only the wc mod 4 leading bytes of the final beat belong to the payload.
   always_comb begin
      beat_mask = 4'b1111;
      if (last_beat) begin
         case (r_q)
            2'd1:    beat_mask = 4'b0001;
            2'd2:    beat_mask = 4'b0011;
            2'd3:    beat_mask = 4'b0111;
            default: beat_mask = 4'b1111;
         endcase
      end
   end

   assign beat_fire = (state == PAYLOAD) && s_valid;
   assign crc_next  = crc_beat(crc_q, s_data, beat_mask);
   assign crc_hold  = crc_q;

   always_ff @(posedge clk) begin
      if (rst || state == IDLE)
         crc_q <= 16'hFFFF;
      else if (beat_fire)
         crc_q <= crc_next;
   end
`else
   assign crc_next = 16'h0000;
   assign crc_hold = 16'h0000;
`endif

   always_comb begin
      last_word = s_data;
      case (r_q)
         2'd1:    last_word = {8'h00, crc_next, s_data[7:0]};
         2'd2:    last_word = {crc_next, s_data[15:0]};
         2'd3:    last_word = {crc_next[7:0], s_data[23:0]};
         default: last_word = s_data;
      endcase
   end

   always_ff @(posedge clk) begin
      mipi_valid    <= 1'b0;
      mipi_data     <= '0;
      end_of_packet <= 1'b0;
      len_err       <= 1'b0;
      underrun      <= 1'b0;
      if (rst) begin
         state      <= IDLE;
         cmd_ready  <= 1'b0;
         s_ready    <= 1'b0;
         r_q        <= 2'd0;
         beats_left <= '0;
         early_last <= 1'b0;
         gap_cnt    <= '0;
      end else begin
         case (state)
            IDLE: begin
               cmd_ready <= 1'b1;
               if (cmd_valid && cmd_ready) begin
                  cmd_ready  <= 1'b0;
                  mipi_valid <= 1'b1;
                  mipi_data  <= header_word;
                  r_q        <= cmd_wc[1:0];
                  beats_left <= beats_total;
                  early_last <= 1'b0;
                  gap_cnt    <= '0;
                  if (is_short) begin
                     end_of_packet <= 1'b1;
                     state         <= GAP;
                  end else if (cmd_wc == 16'd0) begin
                     state <= FOOTER;
                  end else begin
                     s_ready <= 1'b1;
                     state   <= PAYLOAD;
                  end
               end
            end
            PAYLOAD: begin
               if (s_valid) begin
                  mipi_valid <= 1'b1;
                  beats_left <= beats_left - 15'd1;
                  if (last_beat) begin
                     mipi_data <= last_word;
                     len_err   <= early_last | ~s_last;
                     s_ready   <= 1'b0;
                     if (r_q == 2'd1 || r_q == 2'd2) begin
                        end_of_packet <= 1'b1;
                        state         <= GAP;
                     end else begin
                        state <= FOOTER;
                     end
                  end else begin
                     mipi_data <= s_data;
                     if (s_last) early_last <= 1'b1;
                  end
               end else begin
                  underrun <= 1'b1;
               end
            end
            FOOTER: begin
               mipi_valid    <= 1'b1;
               end_of_packet <= 1'b1;
               mipi_data     <= (r_q == 2'd3) ? {24'h000000, crc_hold[15:8]} : {16'h0000, crc_hold};
               state         <= GAP;
            end
            GAP: begin
               if (gap_cnt == GAP_LAST) begin
                  cmd_ready <= 1'b1;
                  state     <= IDLE;
               end else begin
                  gap_cnt <= gap_cnt + 16'd1;
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mipi_tx_packetizer.sv
// Directed bench for mipi_tx_packetizer: expected words are queued as each packet is driven
// and popped as the DUT emits them; CRC and ECC come from independent bit-level models.
module tb_mipi_tx_packetizer;

   localparam int GAP = 4;
`ifdef MIPI_TX_CRC_EN
   localparam bit CRC_ON = 1'b1;
`else
   localparam bit CRC_ON = 1'b0;
`endif

   localparam logic [5:0] SYN [0:23] = '{
      6'h07, 6'h0B, 6'h0D, 6'h0E, 6'h13, 6'h15, 6'h16, 6'h19,
      6'h1A, 6'h1C, 6'h23, 6'h25, 6'h26, 6'h29, 6'h2A, 6'h2C,
      6'h31, 6'h32, 6'h34, 6'h38, 6'h1F, 6'h2F, 6'h37, 6'h3B};

   typedef struct packed {
      logic [31:0] dat;
      logic        eop;
   } exp_t;

   logic        clk, rst;
   logic        cmd_valid, cmd_ready;
   logic [1:0]  cmd_vc;
   logic [5:0]  cmd_dt;
   logic [15:0] cmd_wc;
   logic [31:0] s_data;
   logic        s_valid, s_ready, s_last;
   logic [31:0] mipi_data;
   logic        mipi_valid, end_of_packet, len_err, underrun;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;
   int eop_cnt = 0, len_cnt = 0, und_cnt = 0, srdy_cnt = 0;
   int eop_cyc = 0, len_cyc = 0;
   logic [31:0] last_dat = '0;
   exp_t        exp_q[$];
   int          wcyc[$];
   logic [7:0]  pay[$];

   mipi_tx_packetizer #(.DATA_WIDTH(32), .GAP_CYCLES(GAP)) dut (
      .clk(clk), .rst(rst),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_vc(cmd_vc), .cmd_dt(cmd_dt), .cmd_wc(cmd_wc),
      .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready), .s_last(s_last),
      .mipi_data(mipi_data), .mipi_valid(mipi_valid), .end_of_packet(end_of_packet),
      .len_err(len_err), .underrun(underrun));

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
      end
   endtask

   function automatic logic [5:0] ecc_model(input logic [23:0] d);
      logic [5:0] p;
      p = '0;
      for (int i = 0; i < 24; i++)
         if (d[i]) p ^= SYN[i];
      return p;
   endfunction

   function automatic logic [15:0] crc_model(input int n);
      logic [15:0] c;
      logic        fb;
      c = 16'hFFFF;
      for (int i = 0; i < n; i++)
         for (int b = 0; b < 8; b++) begin
            fb = c[0] ^ pay[i][b];
            c  = c >> 1;
            if (fb) c ^= 16'h8408;
         end
      return CRC_ON ? c : 16'h0000;
   endfunction

   // One clock: sample #1 after the edge, pop/compare emitted words, count pulses.
   task automatic tick();
      exp_t e;
      @(posedge clk);
      #1;
      cyc++;
      if (mipi_valid) begin
         wcyc.push_back(cyc);
         last_dat = mipi_data;
         if (exp_q.size() == 0)
            check("unexpected_word", 32'(exp_q.size()), 32'd1);
         else begin
            e = exp_q.pop_front();
            check("word", mipi_data, e.dat);
            check("eop", 32'(end_of_packet), 32'(e.eop));
         end
      end else if (end_of_packet)
         check("eop_without_valid", 32'(mipi_valid), 32'd1);
      if (end_of_packet) begin eop_cnt++; eop_cyc = cyc; end
      if (len_err) begin len_cnt++; len_cyc = cyc; end
      if (underrun) und_cnt++;
      if (s_ready) srdy_cnt++;
   endtask

   task automatic fill(input int n);
      pay.delete();
      for (int i = 0; i < n + 4; i++) pay.push_back(8'($urandom));
   endtask

   task automatic send_pkt(input logic [1:0] vc, input logic [5:0] dt, input logic [15:0] wc,
                           input int last_mark, input int stall_at, input int stall_len,
                           input int abort_after);
      logic [23:0] h;
      logic [15:0] crc;
      logic [7:0]  ob[$];
      exp_t        e;
      bit          short_p;
      int          nb, nw, acc, und0, len0, eop0, srdy0, exp_len, ecyc;
      short_p = (dt < 6'h10);
      h = {wc, vc, dt};
      e.dat = {2'b00, ecc_model(h), h};
      e.eop = short_p;
      exp_q.push_back(e);
      nb = 0;
      nw = 0;
      if (!short_p) begin
         nb  = (int'(wc) + 3) / 4;
         crc = crc_model(int'(wc));
         for (int i = 0; i < int'(wc); i++) ob.push_back(pay[i]);
         ob.push_back(crc[7:0]);
         ob.push_back(crc[15:8]);
         while (ob.size() % 4 != 0) ob.push_back(8'h00);
         nw = ob.size() / 4;
         for (int k = 0; k < nw; k++) begin
            e.dat = {ob[4*k+3], ob[4*k+2], ob[4*k+1], ob[4*k]};
            e.eop = (k == nw - 1);
            exp_q.push_back(e);
         end
      end
      exp_len = (nb > 0 && last_mark != nb) ? 1 : 0;

      for (int t = 0; t < 50 && !cmd_ready; t++) tick();
      check("cmd_ready_wait", 32'(cmd_ready), 32'd1);
      wcyc.delete();
      und0 = und_cnt; len0 = len_cnt; eop0 = eop_cnt; srdy0 = srdy_cnt;
      cmd_vc = vc; cmd_dt = dt; cmd_wc = wc; cmd_valid = 1'b1;
      tick();
      acc = cyc;
      cmd_valid = 1'b0;

      for (int b = 0; b < nb; b++) begin
         if (abort_after >= 0 && b == abort_after) break;
         if (b == stall_at) begin
            s_valid = 1'b0;
            repeat (stall_len) tick();
         end
         s_data  = {pay[4*b+3], pay[4*b+2], pay[4*b+1], pay[4*b]};
         s_valid = 1'b1;
         s_last  = (b + 1 == last_mark);
         for (int t = 0; t < 20 && !s_ready; t++) tick();
         tick();
      end
      s_valid = 1'b0;
      s_last  = 1'b0;

      if (abort_after >= 0) begin
         rst = 1'b1;
         tick();
         check("abort_ctrl", 32'({mipi_valid, end_of_packet, len_err, underrun, cmd_ready, s_ready}), 32'd0);
         check("abort_data", mipi_data, 32'd0);
         check("abort_no_eop", 32'(eop_cnt - eop0), 32'd0);
         rst = 1'b0;
         exp_q.delete();
         tick();
         return;
      end

      for (int t = 0; t < 40 && eop_cnt == eop0; t++) tick();
      check("eop_count", 32'(eop_cnt - eop0), 32'd1);
      check("hdr_latency", (wcyc.size() > 0) ? 32'(wcyc[0]) : 32'hFFFFFFFF, 32'(acc));
      check("word_count", 32'(wcyc.size()), 32'(nw + 1));
      if (stall_len == 0 && wcyc.size() > 0)
         check("contiguous", 32'(wcyc[$] - wcyc[0]), 32'(nw));
      check("sb_empty", 32'(exp_q.size()), 32'd0);
      check("len_err_count", 32'(len_cnt - len0), 32'(exp_len));
      if (exp_len != 0)
         check("len_err_cycle", 32'(len_cyc), (wcyc.size() > nb) ? 32'(wcyc[nb]) : 32'hFFFFFFFF);
      check("underrun_count", 32'(und_cnt - und0), 32'(stall_len));
      if (short_p)
         check("short_no_s_ready", 32'(srdy_cnt - srdy0), 32'd0);
      ecyc = eop_cyc;
      for (int t = 0; t < GAP + 10 && !cmd_ready; t++) tick();
      check("gap_to_cmd_ready", 32'(cyc - ecyc), 32'(GAP + 1));
   endtask

   initial begin
      logic [7:0] known [0:23] = '{
         8'hFF, 8'h00, 8'h00, 8'h02, 8'hB9, 8'hDC, 8'hF3, 8'h72,
         8'hBB, 8'hD4, 8'hB8, 8'h5A, 8'hC8, 8'h75, 8'hC2, 8'h7C,
         8'h81, 8'hF8, 8'h05, 8'hDF, 8'hFF, 8'h00, 8'h00, 8'h01};

      rst = 1'b1; cmd_valid = 1'b0; cmd_vc = '0; cmd_dt = '0; cmd_wc = '0;
      s_data = '0; s_valid = 1'b0; s_last = 1'b0;
      repeat (3) tick();
      check("reset_ctrl", 32'({mipi_valid, end_of_packet, len_err, underrun, cmd_ready, s_ready}), 32'd0);
      check("reset_data", mipi_data, 32'd0);
      rst = 1'b0;
      tick();
      check("cmd_ready_after_reset", 32'(cmd_ready), 32'd1);

      // Reference packet with a known CRC of 0x00F0.
      pay.delete();
      for (int i = 0; i < 24; i++) pay.push_back(known[i]);
      send_pkt(2'd0, 6'h2B, 16'd24, 6, -1, 0, -1);
      check("known_footer", last_dat, CRC_ON ? 32'h000000F0 : 32'h00000000);

      fill(0);
      send_pkt(2'd1, 6'h00, 16'h0005, 0, -1, 0, -1);
      check("short_word", last_dat, 32'h2F000540);

      fill(5);
      send_pkt(2'd2, 6'h2B, 16'd5, 2, -1, 0, -1);
      fill(7);
      send_pkt(2'd0, 6'h2C, 16'd7, 2, -1, 0, -1);
      fill(0);
      send_pkt(2'd3, 6'h2A, 16'd0, 0, -1, 0, -1);
      fill(6);
      send_pkt(2'd1, 6'h1E, 16'd6, 2, -1, 0, -1);

      // s_last early on beat 2 and a 3-cycle valid drop before beat 4.
      fill(24);
      send_pkt(2'd0, 6'h2B, 16'd24, 2, 3, 3, -1);

      fill(16);
      send_pkt(2'd2, 6'h2B, 16'd16, 4, -1, 0, 2);
      fill(10);
      send_pkt(2'd3, 6'h2B, 16'd10, 3, -1, 0, -1);
      fill(1);
      send_pkt(2'd0, 6'h24, 16'd1, 1, -1, 0, -1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
